// File: rtl/mem_access_unit_if.sv
// Handshake and data-bus bundle for mem_access_unit.
// slave = the unit, master = upstream pipeline plus bus.
interface mem_access_unit_if #(
   parameter int XLEN = 64,
   parameter int AW   = 64
);
   localparam int NB = XLEN / 8;

   logic            in_valid;
   logic            in_ready;
   logic [AW-1:0]   in_addr;
   logic [XLEN-1:0] in_wdata;
   logic [2:0]      in_msize;
   logic            in_read;
   logic            in_write;
   logic            in_unsigned;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_rdata;
   logic            out_misalign;
   logic            stall;

   logic            dreq_valid;
   logic [AW-1:0]   dreq_addr;
   logic [2:0]      dreq_size;
   logic [NB-1:0]   dreq_strobe;
   logic [XLEN-1:0] dreq_data;

   logic            dresp_addr_ok;
   logic            dresp_data_ok;
   logic [XLEN-1:0] dresp_data;

   modport slave (
      input  in_valid, in_addr, in_wdata, in_msize,
      input  in_read, in_write, in_unsigned, out_ready,
      input  dresp_addr_ok, dresp_data_ok, dresp_data,
      output in_ready, out_valid, out_rdata, out_misalign,
      output stall, dreq_valid, dreq_addr, dreq_size,
      output dreq_strobe, dreq_data
   );

   modport master (
      output in_valid, in_addr, in_wdata, in_msize,
      output in_read, in_write, in_unsigned, out_ready,
      output dresp_addr_ok, dresp_data_ok, dresp_data,
      input  in_ready, out_valid, out_rdata, out_misalign,
      input  stall, dreq_valid, dreq_addr, dreq_size,
      input  dreq_strobe, dreq_data
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage bus engine: one load/store per handshake, two-beat
// split of word-crossing accesses when MEM_SPLIT_EN is defined.
module mem_access_unit #(
   parameter int XLEN = 64,
   parameter int AW   = 64
) (
   input  logic         clk,
   input  logic         reset,
   mem_access_unit_if.slave bus
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);

   typedef enum logic [1:0] {
      IDLE, BEAT0, BEAT1, DONE
   } state_t;

   state_t state, state_nx;

   logic [AW-1:0]   addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [2:0]      msize_q;
   logic            rd_q, wr_q, uns_q;
   logic            split_q;
   logic [XLEN-1:0] rdata_q;

   logic            accept, bus_op, in_split, ld, ok;
   logic [OW-1:0]   off;
   logic [2*NB-1:0]   smask;
   logic [2*XLEN-1:0] sdata;
   logic            unused;

   assign accept = bus.in_valid & bus.in_ready;
   assign bus_op = bus.in_read | bus.in_write;
   assign in_split = (32'(bus.in_addr[OW-1:0])
                    + (32'd1 << bus.in_msize)) > 32'(NB);
   assign ld  = rd_q & ~wr_q;
   assign ok  = bus.dresp_data_ok;
   assign off = addr_q[OW-1:0];

   // truncate to 2^sz bytes, then sign/zero fill
   function automatic logic [XLEN-1:0] ext(
      input logic [XLEN-1:0] raw,
      input logic [2:0]      sz,
      input logic            uns
   );
      logic [XLEN-1:0] keep, t;
      logic            fill;
      int              nb;
      nb = 1 << sz;
      if (nb > NB) nb = NB;
      keep = (nb >= NB) ? '1
           : ((XLEN'(1) << (8 * nb)) - XLEN'(1));
      t = raw >> (8 * nb - 1);
      fill = ~uns & t[0];
      return (raw & keep) | ({XLEN{fill}} & ~keep);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept) begin
            if (!bus_op) state_nx = DONE;
`ifndef MEM_SPLIT_EN
            else if (in_split) state_nx = DONE;
`endif
            else state_nx = BEAT0;
         end
         BEAT0: if (ok) begin
`ifdef MEM_SPLIT_EN
            state_nx = split_q ? BEAT1 : DONE;
`else
            state_nx = DONE;
`endif
         end
`ifdef MEM_SPLIT_EN
         BEAT1: if (ok) state_nx = DONE;
`else
         BEAT1: state_nx = IDLE;
`endif
         DONE: if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

`ifdef MEM_SPLIT_EN
   logic [XLEN-1:0]  lbuf;
   logic [OW+3:0]    sh1;
   assign sh1 = {(OW+1)'(NB) - (OW+1)'(off), 3'b000};
   assign unused = bus.dresp_addr_ok;
   assign bus.out_misalign = 1'b0;
`else
   logic mis_q;
   assign unused = ^{bus.dresp_addr_ok,
                     smask[2*NB-1:NB],
                     sdata[2*XLEN-1:XLEN]};
   assign bus.out_misalign = mis_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         msize_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         uns_q   <= 1'b0;
         split_q <= 1'b0;
         rdata_q <= '0;
`ifdef MEM_SPLIT_EN
         lbuf    <= '0;
`else
         mis_q   <= 1'b0;
`endif
      end else begin
         if (accept) begin
            addr_q  <= bus.in_addr;
            wdata_q <= bus.in_wdata;
            msize_q <= bus.in_msize;
            rd_q    <= bus.in_read;
            wr_q    <= bus.in_write;
            uns_q   <= bus.in_unsigned;
            split_q <= in_split;
            rdata_q <= '0;
`ifndef MEM_SPLIT_EN
            mis_q   <= in_split & bus_op;
`endif
         end
         if (state == BEAT0 && ok) begin
`ifdef MEM_SPLIT_EN
            lbuf <= bus.dresp_data >> {off, 3'b000};
            if (ld && !split_q)
`else
            if (ld)
`endif
               rdata_q <= ext(bus.dresp_data >> {off, 3'b000},
                              msize_q, uns_q);
         end
`ifdef MEM_SPLIT_EN
         // high bytes of the result come from lane 0 upward
         if (state == BEAT1 && ok && ld)
            rdata_q <= ext(lbuf | (bus.dresp_data << sh1),
                           msize_q, uns_q);
`endif
      end
   end

   assign smask = wr_q
      ? (((2*NB)'(1) << (32'd1 << msize_q)) - (2*NB)'(1)) << off
      : '0;
   assign sdata = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};

   logic            rq_valid;
   logic [AW-1:0]   rq_addr;
   logic [2:0]      rq_size;
   logic [NB-1:0]   rq_strobe;
   logic [XLEN-1:0] rq_data;

   always_comb begin
      rq_valid  = 1'b0;
      rq_addr   = '0;
      rq_size   = '0;
      rq_strobe = '0;
      rq_data   = '0;
      if (state == BEAT0) begin
         rq_valid  = 1'b1;
         rq_addr   = split_q ? {addr_q[AW-1:OW], {OW{1'b0}}}
                             : addr_q;
         rq_size   = split_q ? 3'(OW) : msize_q;
         rq_strobe = smask[NB-1:0];
         rq_data   = sdata[XLEN-1:0];
      end
`ifdef MEM_SPLIT_EN
      else if (state == BEAT1) begin
         rq_valid  = 1'b1;
         rq_addr   = {addr_q[AW-1:OW], {OW{1'b0}}} + AW'(NB);
         rq_size   = 3'(OW);
         rq_strobe = smask[2*NB-1:NB];
         rq_data   = sdata[2*XLEN-1:XLEN];
      end
`endif
   end

   assign bus.dreq_valid  = rq_valid;
   assign bus.dreq_addr   = rq_addr;
   assign bus.dreq_size   = rq_size;
   assign bus.dreq_strobe = rq_strobe;
   assign bus.dreq_data   = rq_data;

   assign bus.in_ready  = (state == IDLE);
   assign bus.stall     = (state != IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out_rdata = rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table, corner sequences and
// random accesses checked against a byte-level reference model.
module tb_mem_access_unit;
   localparam int XLEN = 64;
   localparam int AW   = 64;
   localparam int NB   = 8;
`ifdef MEM_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_access_unit_if #(.XLEN(XLEN), .AW(AW)) bif();
   mem_access_unit #(.XLEN(XLEN), .AW(AW)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bif)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [2:0]  ms;
      bit          rd, wr, uns;
      logic [63:0] w0, w1;
      logic [63:0] rdata;
      bit          mis;
      int          beats;
      logic [7:0]  strb0;
      int          dly, ordy;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(
      logic [63:0] addr, logic [63:0] wdata, logic [2:0] ms,
      bit rd, bit wr, bit uns, logic [63:0] w0, logic [63:0] w1,
      logic [63:0] rdata, bit mis, int beats, logic [7:0] strb0,
      int dly, int ordy);
      vec_t v;
      v.addr = addr; v.wdata = wdata; v.ms = ms;
      v.rd = rd; v.wr = wr; v.uns = uns;
      v.w0 = w0; v.w1 = w1; v.rdata = rdata; v.mis = mis;
      v.beats = beats; v.strb0 = strb0;
      v.dly = dly; v.ordy = ordy;
      return v;
   endfunction

   // reference model: bytes addr..addr+2^ms-1, beat b covers word b
   function automatic bit crosses(vec_t v);
      return (int'(v.addr[2:0]) + (1 << v.ms)) > NB;
   endfunction

   function automatic void model_beat(
      input vec_t v, input int b,
      output logic [63:0] a, output logic [2:0] sz,
      output logic [7:0] st, output logic [63:0] d,
      output logic [63:0] m);
      int off, n, pos;
      off = int'(v.addr[2:0]);
      n = 1 << v.ms;
      a = crosses(v) ? ({v.addr[63:3], 3'b000} + 64'(8 * b))
                     : v.addr;
      sz = crosses(v) ? 3'd3 : v.ms;
      st = '0; d = '0; m = '0;
      if (v.wr)
         for (int k = 0; k < n; k++) begin
            pos = off + k;
            if (pos / NB == b) begin
               st = st | (8'(1) << (pos % NB));
               m = m | (64'hff << (8 * (pos % NB)));
               d = d | (((v.wdata >> (8 * k)) & 64'hff)
                        << (8 * (pos % NB)));
            end
         end
   endfunction

   function automatic logic [63:0] model_load(vec_t v);
      int off, n, pos;
      logic [63:0] val, by;
      if (!(v.rd && !v.wr)) return 64'h0;
      if (crosses(v) && !SPLIT) return 64'h0;
      off = int'(v.addr[2:0]);
      n = 1 << v.ms;
      val = '0;
      for (int k = 0; k < n; k++) begin
         pos = off + k;
         by = (pos < NB) ? ((v.w0 >> (8 * pos)) & 64'hff)
                         : ((v.w1 >> (8 * (pos - NB))) & 64'hff);
         val = val | (by << (8 * k));
      end
      if (!v.uns && n < NB && ((val >> (8 * n - 1)) & 64'h1) != 0)
         val = val | (~64'h0 << (8 * n));
      return val;
   endfunction

   task automatic run(input vec_t v);
      int cyc, b, w, exp_cyc;
      bit done;
      logic [63:0] ea, ed, em, held;
      logic [2:0] es;
      logic [7:0] est;
      @(negedge clk);
      chk("in_ready_idle", 64'(bif.in_ready), 64'h1);
      bif.in_valid    = 1'b1;
      bif.in_addr     = v.addr;
      bif.in_wdata    = v.wdata;
      bif.in_msize    = v.ms;
      bif.in_read     = v.rd;
      bif.in_write    = v.wr;
      bif.in_unsigned = v.uns;
      cyc = 0; b = 0; w = 0; done = 1'b0;
      @(posedge clk);
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         bif.in_valid = 1'b0;
         bif.dresp_data_ok = 1'b0;
         bif.dresp_data = {$urandom, $urandom};
         if (bif.out_valid) done = 1'b1;
         else begin
            chk("stall_busy", 64'(bif.stall), 64'h1);
            chk("in_ready_busy", 64'(bif.in_ready), 64'h0);
            chk("dreq_valid_busy", 64'(bif.dreq_valid), 64'h1);
            if (bif.dreq_valid) begin
               model_beat(v, b, ea, es, est, ed, em);
               chk("dreq_addr", bif.dreq_addr, ea);
               chk("dreq_size", 64'(bif.dreq_size), 64'(es));
               chk("dreq_strobe", 64'(bif.dreq_strobe), 64'(est));
               chk("dreq_data", bif.dreq_data & em, ed);
               if (b == 0)
                  chk("strobe_beat0", 64'(bif.dreq_strobe),
                      64'(v.strb0));
               if (w == v.dly) begin
                  bif.dresp_data_ok = 1'b1;
                  bif.dresp_data = (b == 0) ? v.w0 : v.w1;
                  b++;
                  w = 0;
               end else w++;
            end
         end
      end
      chk("completed", 64'(done), 64'h1);
      exp_cyc = (v.beats == 0) ? 1 : v.beats * (v.dly + 1) + 1;
      chk("beats", 64'(b), 64'(v.beats));
      chk("latency", 64'(cyc), 64'(exp_cyc));
      chk("out_rdata", bif.out_rdata, v.rdata);
      chk("out_misalign", 64'(bif.out_misalign), 64'(v.mis));
      chk("dreq_off_done", 64'(bif.dreq_valid), 64'h0);
      held = bif.out_rdata;
      for (int i = 0; i < v.ordy; i++) begin
         @(negedge clk);
         chk("hold_valid", 64'(bif.out_valid), 64'h1);
         chk("hold_rdata", bif.out_rdata, v.rdata);
         chk("hold_in_ready", 64'(bif.in_ready), 64'h0);
         chk("hold_stall", 64'(bif.stall), 64'h1);
      end
      bif.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bif.out_ready = 1'b0;
      chk("exit_valid", 64'(bif.out_valid), 64'h0);
      chk("exit_in_ready", 64'(bif.in_ready), 64'h1);
      chk("exit_stall", 64'(bif.stall), 64'h0);
      if (held !== v.rdata) $display("note: rdata drift");
   endtask

   vec_t tbl[12];
   vec_t v;
   logic [63:0] ra, rd_, rm;
   logic [2:0] rs;
   logic [7:0] rst_;

   initial begin
      bif.in_valid = 0; bif.in_addr = 0; bif.in_wdata = 0;
      bif.in_msize = 0; bif.in_read = 0; bif.in_write = 0;
      bif.in_unsigned = 0; bif.out_ready = 0;
      bif.dresp_addr_ok = 0; bif.dresp_data_ok = 0;
      bif.dresp_data = 0;

      tbl[0] = mk(64'h1000, 0, 3, 1, 0, 0, 64'h8877665544332211, 0,
                  64'h8877665544332211, 0, 1, 8'h00, 0, 0);
      tbl[1] = mk(64'h1005, 0, 0, 1, 0, 0, 64'h000080FF00000000, 0,
                  64'hFFFFFFFFFFFFFF80, 0, 1, 8'h00, 0, 0);
      tbl[2] = mk(64'h1005, 0, 0, 1, 0, 1, 64'h000080FF00000000, 0,
                  64'h80, 0, 1, 8'h00, 0, 0);
      tbl[3] = mk(64'h2006, 64'hBEEF, 1, 0, 1, 0, 0, 0,
                  64'h0, 0, 1, 8'hC0, 0, 0);
      tbl[4] = mk(64'h2000, 64'h55, 3, 0, 0, 0, 0, 0,
                  64'h0, 0, 0, 8'h00, 0, 0);
      tbl[5] = mk(64'h0010, 64'h12345678, 2, 1, 1, 0, 0, 0,
                  64'h0, 0, 1, 8'h0F, 0, 0);
      tbl[6] = mk(64'h4002, 0, 1, 1, 0, 0, 64'h000000009ABC0000, 0,
                  64'hFFFFFFFFFFFF9ABC, 0, 1, 8'h00, 0, 0);
      tbl[7] = mk(64'h4004, 0, 2, 1, 0, 0, 64'h7FFFFFFF00000000, 0,
                  64'h000000007FFFFFFF, 0, 1, 8'h00, 0, 1);
      tbl[8] = mk(64'h1000, 0, 3, 1, 0, 0, 64'h0123456789ABCDEF, 0,
                  64'h0123456789ABCDEF, 0, 1, 8'h00, 3, 2);
      tbl[9] = mk(64'h5004, 0, 2, 1, 0, 0, 64'h8000000100000000, 0,
                  64'hFFFFFFFF80000001, 0, 1, 8'h00, 0, 0);
      tbl[10] = mk(64'h3006, 0, 2, 1, 0, 0, 64'hDDCC000000000000,
                   64'h112233445566BBAA,
                   SPLIT ? 64'hFFFFFFFFBBAADDCC : 64'h0,
                   !SPLIT, SPLIT ? 2 : 0, 8'h00, 0, 0);
      tbl[11] = mk(64'h2007, 64'h0102030405060708, 3, 0, 1, 0, 0, 0,
                   64'h0, !SPLIT, SPLIT ? 2 : 0, 8'h80, 1, 1);

      #2;
      chk("rst_in_ready", 64'(bif.in_ready), 64'h1);
      chk("rst_out_valid", 64'(bif.out_valid), 64'h0);
      chk("rst_stall", 64'(bif.stall), 64'h0);
      chk("rst_dreq_valid", 64'(bif.dreq_valid), 64'h0);
      chk("rst_dreq_addr", bif.dreq_addr, 64'h0);
      chk("rst_dreq_strobe", 64'(bif.dreq_strobe), 64'h0);
      chk("rst_out_rdata", bif.out_rdata, 64'h0);
      chk("rst_misalign", 64'(bif.out_misalign), 64'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) run(tbl[i]);

      // reset while BEAT0 is waiting for data_ok
      @(negedge clk);
      bif.in_valid = 1'b1; bif.in_addr = 64'h1000;
      bif.in_msize = 3'd3; bif.in_read = 1'b1; bif.in_write = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bif.in_valid = 1'b0;
      chk("mid_dreq_valid", 64'(bif.dreq_valid), 64'h1);
      reset = 1'b1;
      #1;
      chk("mid_rst_dreq", 64'(bif.dreq_valid), 64'h0);
      chk("mid_rst_ready", 64'(bif.in_ready), 64'h1);
      chk("mid_rst_stall", 64'(bif.stall), 64'h0);
      @(negedge clk);
      reset = 1'b0;
      run(tbl[1]);

      for (int i = 0; i < 150; i++) begin
         v.addr = {$urandom, $urandom};
         v.wdata = {$urandom, $urandom};
         v.ms = 3'($urandom_range(0, 3));
         v.rd = 1'($urandom); v.wr = 1'($urandom);
         v.uns = 1'($urandom);
         v.w0 = {$urandom, $urandom};
         v.w1 = {$urandom, $urandom};
         v.dly = $urandom_range(0, 2);
         v.ordy = $urandom_range(0, 1);
         v.rdata = model_load(v);
         v.mis = (v.rd || v.wr) && crosses(v) && !SPLIT;
         v.beats = !(v.rd || v.wr) ? 0
                 : crosses(v) ? (SPLIT ? 2 : 0) : 1;
         model_beat(v, 0, ra, rs, rst_, rd_, rm);
         v.strb0 = rst_;
         run(v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-stage bus engine that replaces the single-cycle combinational data-bus path between the execute and writeback stages. It accepts one load/store per handshake, drives the data bus through a request FSM that holds the request stable until `data_ok`, splits accesses that cross a bus-word boundary into two beats, and returns sign/zero-extended load data on a valid/ready output. It raises `stall` to freeze the upstream pipeline while a transaction is in flight.

## Interface
- `XLEN`, 64: data and bus-word width in bits; must be a power of two, ≥ 16. `NB = XLEN/8` is the number of bytes per bus word; `OW = log2(NB)` is the offset width.
- `AW`, 64: address width.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: an access is offered.
- `in_ready` out 1: the unit accepts the access; high only in IDLE.
- `in_addr` in AW: byte address.
- `in_wdata` in XLEN: store data, right-aligned.
- `in_msize` in 3: log2 of the access size in bytes; values 0 to OW are legal.
- `in_read` in 1: load.
- `in_write` in 1: store.
- `in_unsigned` in 1: zero-extend the load result.
- `out_valid` out 1: a result is available.
- `out_ready` in 1: downstream accepts the result.
- `out_rdata` out XLEN: extended load data; 0 for stores and pass-through operations.
- `out_misalign` out 1: the access crossed a word boundary and was not performed. Valid only with `MEM_SPLIT_EN` undefined.
- `stall` out 1: high whenever the state is not IDLE.
- `dreq_valid` out 1, `dreq_addr` out AW, `dreq_size` out 3, `dreq_strobe` out NB, `dreq_data` out XLEN: data-bus request.
- `dresp_addr_ok` in 1, `dresp_data_ok` in 1, `dresp_data` in XLEN: data-bus response.

## Operation
- States:
  - IDLE: `in_ready=1`.
  - BEAT0 / BEAT1: drive the request.
  - DONE: hold the result.
- Accept on `in_valid & in_ready`. On accept, latch addr, wdata, msize, read/write, unsigned, and split = `(addr[OW-1:0] + (1<<msize)) > NB`.
- Operation with `in_read = in_write = 0`: go IDLE→DONE, no bus activity, `out_rdata = 0`.
- `in_read & in_write` both high: treat as a store.
- Unsplit access:
  - One beat.
  - `dreq_addr` = latched addr.
  - `dreq_size` = msize.
  - `dreq_strobe` = (`(1<<2^msize)-1`) << offset for stores, 0 for loads.
  - `dreq_data` = wdata << (8·offset).
- Split access (`MEM_SPLIT_EN` defined):
  - BEAT0: addr = aligned base, size = OW, low part of the strobe/data shifted as above with overflow bytes dropped.
  - BEAT1: addr = aligned base + NB, size = OW, strobe/data = overflow bytes at lane 0 upward.
- Load assembly:
  - BEAT0 returns bytes `[NB-1:offset]` into result bytes `[NB-1-offset:0]`.
  - BEAT1 returns lanes from 0 into the remaining high bytes.
  - Then truncate to `2^msize` bytes and sign- or zero-extend to XLEN.
- Beat completion: a beat completes on the cycle `dresp_data_ok=1`. BEAT0 then moves to BEAT1 if split, else to DONE. BEAT1 moves to DONE.
- DONE:
  - `out_valid=1`, with `out_rdata` and `out_misalign` held.
  - Transition to IDLE on `out_ready`.
  - `in_ready` stays 0 in DONE; there is no same-cycle re-accept.

## Timing
- Reset (asynchronous, takes effect immediately): state=IDLE. All outputs 0 except `in_ready=1`. `dreq_*` = 0.
- Request hold rule: `dreq_valid` is high for the entire BEATn state. All `dreq_*` fields are stable from assertion until `data_ok`. `dresp_addr_ok` is ignored for sequencing.
- Minimum latency, aligned access with `data_ok` in its first request cycle:
  - cycle 0: accept.
  - cycle 1: BEAT0, `dreq_valid=1`, `data_ok=1`.
  - cycle 2: DONE, `out_valid=1`.
- Split access: one extra cycle minimum.
- `dreq_valid` deasserts in the cycle after the final `data_ok` (DONE).
- `out_rdata` is registered; it does not combinationally depend on `dresp_data`.
- Reset asserted mid-beat: the request is dropped immediately. The bus is responsible for discarding the outstanding beat.

## Configuration
- `MEM_SPLIT_EN` defined: accesses crossing a word boundary are split into two beats as above; `out_misalign` is tied 0.
- `MEM_SPLIT_EN` undefined: a crossing access goes IDLE→DONE with no bus request, `out_misalign=1`, `out_rdata=0`. BEAT1 logic is not built.

## Test plan
- Aligned load, XLEN=64: addr 0x1000, msize 3, bus returns 0x8877665544332211 at the first `data_ok` → `out_valid` 2 cycles after accept, `out_rdata` = 0x8877665544332211.
- Signed byte load: addr 0x1005, msize 0, returned word 0x0000_80FF_0000_0000 → `out_rdata` = 0xFFFF_FFFF_FFFF_FF80. Repeat with `in_unsigned=1` → 0x80.
- Store half: addr 0x2006, wdata 0xBEEF → one beat, `dreq_strobe` = 0xC0, `dreq_data[63:48]` = 0xBEEF, `dreq_size` = 1.
- Split word load (`MEM_SPLIT_EN`): addr 0x3006, msize 2. BEAT0 at 0x3000 returns 0xDDCC_0000_0000_0000; BEAT1 at 0x3008 returns 0x...BBAA → `out_rdata` = 0xFFFF_FFFF_BBAA_DDCC. `stall` is high from accept to DONE exit.
- Back-pressure and slow bus: `data_ok` delayed 3 cycles with `dreq_*` checked stable each cycle; `out_ready` held low 2 cycles → `out_valid` and `out_rdata` held, `in_ready=0` throughout.
- Reset mid-BEAT0: `dreq_valid` drops in the same cycle; after release, `in_ready=1` and a new access completes normally. Without `MEM_SPLIT_EN`: addr 0x3006 with msize 2 → `out_misalign=1`, no `dreq_valid`.
